fetch_control_unit: RTL
=======================

# fetch_control_unit

Program-counter and fetch sequencer that sits directly upstream of the instruction memory. It drives the 10-bit fetch address and receives the 32-bit instruction word back combinationally. It decodes only the control-flow and I/O opcodes, and stalls the single-cycle datapath on `in`/`out` handshakes. It issues a one-cycle `commit` strobe per retired instruction and halts cleanly at the end of the program image.

## Interface
- `ADDR_WIDTH`, 10, width of the fetch address.
- `LAST_ADDR`, 55, highest valid instruction-memory word.
- `BOOT_ADDR`, 0, PC value after reset.
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-low; sampled on posedge `clock`.
- `adress` out ADDR_WIDTH: fetch address to the instruction memory (registered PC).
- `instruction` in 32: instruction word returned for `adress`, same cycle.
- `branch_cond` in 1: compare result from the datapath for the current instruction, valid the same cycle.
- `in_valid` in 1: external input word available.
- `in_ack` out 1: input word consumed this cycle.
- `out_ready` in 1: external sink accepts the output word.
- `out_valid` out 1: output word presented.
- `commit` out 1: current instruction retires this cycle; the datapath writes the register file and data memory only when this is 1.
- `halted` out 1: sequencer stopped.
- `fetch_error` out 1: a jump or branch targeted an address above LAST_ADDR.
- `retired_count` out 16: number of retired instructions, saturating at 16'hFFFF.

## Operation
- Opcode is `instruction[31:26]` and target is `instruction[9:0]`.
- **Jump** (6'b001110): always taken.
- **Conditional branches** (6'b010111, 6'b011010, 6'b011011, 6'b011100, 6'b011101, 6'b011110): taken iff `branch_cond` = 1.
- **IN** = 6'b011111 and **OUT** = 6'b100000. All other opcodes, including nop, are sequential.
- **States:** BOOT, RUN, WAIT_IN, WAIT_OUT, HALT.
- **BOOT:** one cycle; `commit` = 0, PC = BOOT_ADDR. This cycle lets the instruction memory complete its load on its first posedge. Next state is RUN.
- **RUN, sequential instruction:** `commit` = 1; PC ← PC+1.
- **RUN, taken jump/branch:** `commit` = 1; PC ← target.
- **RUN, not-taken branch:** `commit` = 1; PC ← PC+1.
- **RUN, IN with `in_valid` = 1:** `in_ack` = 1, `commit` = 1, PC ← PC+1 (zero-wait).
- **RUN, IN with `in_valid` = 0:** `commit` = 0; go to WAIT_IN.
- **WAIT_IN:** hold PC. On the first cycle with `in_valid` = 1: `in_ack` = 1, `commit` = 1, PC ← PC+1, return to RUN.
- **OUT:** `out_valid` = 1 combinationally while state is RUN/WAIT_OUT and opcode is OUT.
  - If `out_ready` = 1: `commit` = 1, PC ← PC+1, stay in or return to RUN.
  - Otherwise: go to or stay in WAIT_OUT with PC held.
- **End of image:** if the next PC on a sequential retire would be LAST_ADDR+1, the instruction still commits and the state goes to HALT. PC stays at LAST_ADDR.
- **Out-of-range target:** a taken target above LAST_ADDR still commits the branch. Then `fetch_error` ← 1, state ← HALT, and PC is unchanged.
- **HALT:** all strobes 0; PC frozen. Only reset exits.
- **retired_count:** increments on every `commit` and saturates at its maximum.
- **Reset values** (`reset` = 0 at posedge): PC = BOOT_ADDR, state = BOOT, `commit`/`in_ack`/`out_valid` = 0, `halted` = 0, `fetch_error` = 0, `retired_count` = 0.
- **Reset mid-operation:** reset in WAIT_IN, WAIT_OUT or HALT abandons the handshake. `out_valid` drops in the reset cycle and no `in_ack` is issued.

## Timing
- `adress` is a register. `commit`, `in_ack` and `out_valid` are combinational from state, `instruction`, `branch_cond`, `in_valid` and `out_ready`.
- `halted` and `fetch_error` are registered.
- Throughput is one instruction per cycle in RUN. Each IN/OUT adds one cycle per cycle of handshake wait.
- Branch resolution has zero latency: the target is fetched on the cycle after the branch commits.
- `in_valid` and `out_ready` may change on any cycle; only their value at the posedge matters.
- `halted` rises on the posedge after the last commit.

## Test plan
- **Reset/boot:** hold `reset` = 0 for 2 cycles, then release → `adress` = 0 and `commit` = 0 for one cycle, then `commit` = 1 with `adress` sequence 0, 1, 2…
- **Jump and branches:**
  - J to 30 at address 17 → next `adress` = 30; `retired_count` +1.
  - Branch at 38 with `branch_cond` = 1 → 40.
  - Branch at 41 with `branch_cond` = 0 → 42.
- **IN stall:** IN at address 1 with `in_valid` low for 3 cycles → `adress` holds 1 for 3 cycles with `commit` = 0. In the 4th cycle `in_ack` = `commit` = 1, then `adress` = 2.
- **OUT backpressure:** OUT with `out_ready` = 0 for 2 cycles → `out_valid` = 1 for 3 cycles and a single `commit`, then PC+1.
- **End of image:** sequential retire at 55 → `commit` = 1, then `halted` = 1 with `adress` = 55. Further cycles give no strobes and `retired_count` is frozen.
- **Error and reset recovery:** J to 60 → `fetch_error` = 1, `halted` = 1. Assert `reset` = 0 during WAIT_OUT → `out_valid` drops immediately, and after release the sequencer restarts at BOOT with all flags cleared.

Source files
------------

// File: rtl/fetch_control_unit.sv
// rtl/fetch_control_unit.sv - program counter and fetch sequencer with IN/OUT handshake stalls
module fetch_control_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int LAST_ADDR  = 55,
  parameter int BOOT_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] adress,
  input  logic [31:0]           instruction,
  input  logic                  branch_cond,
  input  logic                  in_valid,
  output logic                  in_ack,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  commit,
  output logic                  halted,
  output logic                  fetch_error,
  output logic [15:0]           retired_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BOOT_PC = ADDR_WIDTH'(BOOT_ADDR);

  localparam logic [5:0] OP_JUMP = 6'b001110;
  localparam logic [5:0] OP_IN   = 6'b011111;
  localparam logic [5:0] OP_OUT  = 6'b100000;

  typedef enum logic [2:0] {
    S_BOOT,
    S_RUN,
    S_WAIT_IN,
    S_WAIT_OUT,
    S_HALT
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    halted_q, halted_d;
  logic                    fetch_error_q, fetch_error_d;
  logic [15:0]             retired_count_q, retired_count_d;

  logic [5:0]              opcode;
  logic [ADDR_WIDTH-1:0]   target;
  logic                    is_jump, is_branch, is_in, is_out;
  logic                    commit_c, in_ack_c, out_valid_c, seq_adv;
  logic                    unused_instr_bits;

  assign opcode            = instruction[31:26];
  assign target            = instruction[ADDR_WIDTH-1:0];
  assign unused_instr_bits = ^instruction[25:ADDR_WIDTH];

  always_comb begin
    is_jump   = (opcode == OP_JUMP);
    is_in     = (opcode == OP_IN);
    is_out    = (opcode == OP_OUT);
    is_branch = 1'b0;
    case (opcode)
      6'b010111, 6'b011010, 6'b011011,
      6'b011100, 6'b011101, 6'b011110: is_branch = 1'b1;
      default:                         is_branch = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_error_d = fetch_error_q;
    commit_c      = 1'b0;
    in_ack_c      = 1'b0;
    out_valid_c   = 1'b0;
    seq_adv       = 1'b0;

    case (state_q)
      S_BOOT: begin
        pc_d    = BOOT_PC;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (is_in) begin
          if (in_valid) begin
            in_ack_c = 1'b1;
            commit_c = 1'b1;
            seq_adv  = 1'b1;
          end else begin
            state_d = S_WAIT_IN;
          end
        end else if (is_out) begin
          out_valid_c = 1'b1;
          if (out_ready) begin
            commit_c = 1'b1;
            seq_adv  = 1'b1;
          end else begin
            state_d = S_WAIT_OUT;
          end
        end else if (is_jump || (is_branch && branch_cond)) begin
          commit_c = 1'b1;
          // The branch itself retires even when its target is unreachable.
          if (target > LAST_PC) begin
            fetch_error_d = 1'b1;
            state_d       = S_HALT;
          end else begin
            pc_d = target;
          end
        end else begin
          commit_c = 1'b1;
          seq_adv  = 1'b1;
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          in_ack_c = 1'b1;
          commit_c = 1'b1;
          seq_adv  = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_WAIT_OUT: begin
        out_valid_c = is_out;
        if (out_ready) begin
          commit_c = 1'b1;
          seq_adv  = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase

    // Retiring the last image word halts instead of running off the end.
    if (seq_adv) begin
      if (pc_q == LAST_PC) begin
        state_d = S_HALT;
      end else begin
        pc_d = pc_q + ADDR_WIDTH'(1);
      end
    end

    halted_d = (state_d == S_HALT);

    retired_count_d = retired_count_q;
    if (commit_c && (retired_count_q != 16'hFFFF)) begin
      retired_count_d = retired_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= S_BOOT;
      pc_q            <= BOOT_PC;
      halted_q        <= 1'b0;
      fetch_error_q   <= 1'b0;
      retired_count_q <= 16'd0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      halted_q        <= halted_d;
      fetch_error_q   <= fetch_error_d;
      retired_count_q <= retired_count_d;
    end
  end

  // Strobes are masked while reset is low so a pending handshake is dropped at once.
  assign commit        = commit_c & reset;
  assign in_ack        = in_ack_c & reset;
  assign out_valid     = out_valid_c & reset;
  assign adress        = pc_q;
  assign halted        = halted_q;
  assign fetch_error   = fetch_error_q;
  assign retired_count = retired_count_q;

endmodule
